// File: rtl/switch_block_cfg_loader.sv
// Serial configuration loader for bidir_switch_block: shifts a select frame plus CRC-8 into a
// shadow register and commits it to the select bus only when the received CRC matches.
module switch_block_cfg_loader #(
  parameter int unsigned      SEL_W    = 108,
  parameter int unsigned      CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = 8'h07
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [SEL_W-1:0] select,
  output logic             sel_valid,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int unsigned     FrameLen = SEL_W + CRC_W;
  localparam int unsigned     CntW     = $clog2(FrameLen);
  localparam logic [CntW-1:0] LastData = CntW'(SEL_W - 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(FrameLen - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StCommit,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]   shadow_q, shadow_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   rx_crc_q, rx_crc_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic               sel_valid_q, sel_valid_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;
  logic               fb;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    select_d    = select_q;
    sel_valid_d = sel_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    // A start pulse outranks any bit presented in the same cycle.
    accept      = cfg_valid && ready_q && (state_q == StShift) && !cfg_start;
    fb          = crc_q[CRC_W-1] ^ cfg_bit;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StShift: begin
        if (accept) begin
          if (cnt_q <= LastData) begin
            shadow_d[cnt_q] = cfg_bit;
            crc_d           = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
          end else begin
            rx_crc_d = {rx_crc_q[CRC_W-2:0], cfg_bit};
          end
          if (cnt_q == LastBit) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StCheck: state_d = (rx_crc_q == crc_q) ? StCommit : StErr;
      StCommit: begin
        select_d    = shadow_q;
        sel_valid_d = 1'b1;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Restart from any state; a commit in flight still completes.
    if (cfg_start) begin
      cnt_d    = '0;
      crc_d    = '0;
      rx_crc_d = '0;
      err_d    = 1'b0;
      state_d  = StShift;
    end

    ready_d = (state_d == StShift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      crc_q       <= '0;
      rx_crc_q    <= '0;
      select_q    <= '0;
      sel_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      select_q    <= select_d;
      sel_valid_q <= sel_valid_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign select    = select_q;
  assign sel_valid = sel_valid_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done_q && err_q));
  a_ready_in_shift: assert property (@(posedge clk) disable iff (!rst_n)
                                     ready_q |-> (state_q == StShift));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LastBit);

endmodule

// File: tb/tb_switch_block_cfg_loader.sv
// Randomized bench for switch_block_cfg_loader, checked against a polynomial-division CRC model.
module tb_switch_block_cfg_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic         cfg_bit = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [107:0] select;
  logic         sel_valid;
  logic         cfg_done;
  logic         cfg_err;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;

  logic [107:0] model_sel = '0;
  logic         model_valid = 1'b0;

  always #5 clk = ~clk;

  switch_block_cfg_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .select   (select),
    .sel_valid(sel_valid),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always @(negedge clk) begin
    if (cfg_done) done_seen++;
    if (cfg_err) err_seen++;
    if (cfg_done && cfg_err) both_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of (stream * x^8) mod (x^8+x^2+x+1); stream order is d[0] first.
  function automatic logic [7:0] model_crc(input logic [107:0] d);
    logic [115:0] m;
    m = '0;
    for (int i = 0; i < 108; i++) m[115-i] = d[i];
    for (int k = 115; k >= 8; k--) begin
      if (m[k]) m[k-:9] = m[k-:9] ^ 9'h107;
    end
    return m[7:0];
  endfunction

  function automatic logic stream_bit(input logic [107:0] d, input logic [7:0] c, input int k);
    if (k < 108) return d[k];
    return c[7-(k-108)];
  endfunction

  function automatic logic [107:0] rand_frame();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[107:0];
  endfunction

  task automatic send_bit(input logic b, input int gap_pct);
    int w;
    while ($urandom_range(99) < gap_pct) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
      tick();
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    w = 0;
    while (cfg_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout cfg_ready=%b want=1 within 200 cycles", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [107:0] d, input logic [7:0] c, input int nbits,
                             input int gap_pct);
    for (int k = 0; k < nbits; k++) send_bit(stream_bit(d, c, k), gap_pct);
  endtask

  task automatic start_pulse(input logic with_bit);
    cfg_start = 1'b1;
    cfg_valid = with_bit;
    cfg_bit   = 1'($urandom);
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      tick();
      n_checks++;
      if (select !== '0 || sel_valid !== 1'b0 || cfg_ready !== 1'b0 ||
          cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d sel=%h sv=%b rdy=%b done=%b err=%b want all 0",
                 i, select, sel_valid, cfg_ready, cfg_done, cfg_err);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_zero_frame();
    start_pulse(1'b0);
    send_stream('0, 8'h00, 116, 0);
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ready_drop got=%b want=0", cfg_ready);
    end
    tick();
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_early done/err got=%b%b want=00", cfg_done, cfg_err);
    end
    tick();
    model_sel   = '0;
    model_valid = 1'b1;
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b10 || select !== model_sel || sel_valid !== model_valid) begin
      n_fail++;
      $display("FAIL zero_commit done/err=%b%b sel=%h sv=%b want 10 sel=0 sv=1",
               cfg_done, cfg_err, select, sel_valid);
    end
    tick();
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_pulse_len done/err got=%b%b want=00", cfg_done, cfg_err);
    end
  endtask

  task automatic test_crc_error();
    logic [107:0] d;
    d = 108'h1;
    start_pulse(1'b0);
    send_stream(d, model_crc(d), 116, 0);
    tick();
    tick();
    model_sel = d;
    n_checks++;
    if (cfg_done !== 1'b1 || select !== model_sel) begin
      n_fail++;
      $display("FAIL one_commit done=%b sel=%h want done=1 sel=%h", cfg_done, select, model_sel);
    end
    tick();
    start_pulse(1'b0);
    send_stream('0, 8'h01, 116, 0);
    tick();
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL bad_early done/err got=%b%b want=00", cfg_done, cfg_err);
    end
    tick();
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b01 || select !== model_sel || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_crc done/err=%b%b sel=%h sv=%b want 01 sel=%h sv=1",
               cfg_done, cfg_err, select, sel_valid, model_sel);
    end
    tick();
    n_checks++;
    if ({cfg_done, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL bad_pulse_len done/err got=%b%b want=00", cfg_done, cfg_err);
    end
  endtask

  task automatic test_random_gaps();
    logic [107:0] d;
    logic [7:0]   c;
    logic         ok;
    for (int i = 0; i < 4; i++) begin
      d  = rand_frame();
      ok = (i != 2);
      c  = ok ? model_crc(d) : model_crc(d) ^ 8'($urandom_range(1, 255));
      start_pulse(1'b0);
      send_stream(d, c, 115, 30);
      n_checks++;
      if (cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd%0d_ready_115 got=%b want=1", i, cfg_ready);
      end
      send_bit(stream_bit(d, c, 115), 30);
      n_checks++;
      if (cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_ready_116 got=%b want=0", i, cfg_ready);
      end
      tick();
      tick();
      if (ok) begin
        model_sel   = d;
        model_valid = 1'b1;
      end
      n_checks++;
      if ({cfg_done, cfg_err} !== {ok, !ok} || select !== model_sel || sel_valid !== model_valid)
      begin
        n_fail++;
        $display("FAIL rnd%0d_result done/err=%b%b sel=%h want %b%b sel=%h",
                 i, cfg_done, cfg_err, select, ok, !ok, model_sel);
      end
      tick();
    end
  endtask

  task automatic test_restart();
    logic [107:0] d1;
    logic [107:0] d2;
    int           done0;
    int           err0;
    d1    = rand_frame();
    d2    = rand_frame();
    done0 = done_seen;
    err0  = err_seen;
    start_pulse(1'b0);
    send_stream(d1, model_crc(d1), 50, 10);
    start_pulse(1'b1);
    send_stream(d2, model_crc(d2), 116, 10);
    tick();
    tick();
    tick();
    model_sel = d2;
    n_checks++;
    if (done_seen - done0 != 1 || err_seen != err0) begin
      n_fail++;
      $display("FAIL restart_pulses done=%0d err=%0d want done=1 err=0",
               done_seen - done0, err_seen - err0);
    end
    n_checks++;
    if (select !== model_sel) begin
      n_fail++;
      $display("FAIL restart_select got=%h want=%h", select, model_sel);
    end
  endtask

  task automatic test_reset_midframe();
    logic [107:0] d;
    d = rand_frame();
    start_pulse(1'b0);
    send_stream(d, model_crc(d), 112, 0);
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    model_sel   = '0;
    model_valid = 1'b0;
    n_checks++;
    if (select !== model_sel || sel_valid !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset sel=%h sv=%b rdy=%b want 0/0/0", select, sel_valid, cfg_ready);
    end
    rst_n = 1'b1;
    tick();
    d = rand_frame();
    start_pulse(1'b0);
    send_stream(d, model_crc(d), 116, 20);
    tick();
    tick();
    model_sel   = d;
    model_valid = 1'b1;
    n_checks++;
    if (cfg_done !== 1'b1 || select !== model_sel || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_commit done=%b sel=%h sv=%b want 1 sel=%h sv=1",
               cfg_done, select, sel_valid, model_sel);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_crc_error();
    test_random_gaps();
    test_restart();
    test_reset_midframe();
    n_checks++;
    if (both_seen != 0) begin
      n_fail++;
      $display("FAIL done_err_overlap got=%0d want=0", both_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
